// File: rtl/count_cmd_seq_pkg.sv
`default_nettype none
// ============================================================================
// Module : count_cmd_seq_pkg
// Brief  : Shared types for the counter command sequencer: command opcodes,
//          sequencer FSM states and the default-width command record.
// Rev    : 1.0  initial release
// ============================================================================
package count_cmd_seq_pkg;

    localparam int c_DATA_W_DEF = 4;
    localparam int c_LEN_W_DEF  = 8;

    typedef enum logic [1:0] {
        OP_LOAD = 2'b00,
        OP_UP   = 2'b01,
        OP_DOWN = 2'b10,
        OP_RSVD = 2'b11
    } cmd_op_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2
    } cmd_state_e;

    typedef struct packed {
        cmd_op_e                 op;
        logic [c_DATA_W_DEF-1:0] data;
        logic [c_LEN_W_DEF-1:0]  len;
    } cmd_t;

    // A command occupies at least one drive cycle only if it is a LOAD or a
    // count with a non-zero length; everything else retires without driving.
    function automatic logic is_drive_cmd(input cmd_op_e op, input logic len_nz);
        return (op == OP_LOAD) || (((op == OP_UP) || (op == OP_DOWN)) && len_nz);
    endfunction

endpackage : count_cmd_seq_pkg
`default_nettype wire

// File: rtl/count_cmd_seq_if.sv
`default_nettype none
// ============================================================================
// Module : count_cmd_seq_if
// Brief  : valid/ready command channel into the counter command sequencer.
// Rev    : 1.0  initial release
// ============================================================================
interface count_cmd_seq_if #(
    parameter int DATA_W = 4,
    parameter int LEN_W  = 8
) ();
    import count_cmd_seq_pkg::*;

    logic              cmd_valid;
    logic              cmd_ready;
    cmd_op_e           cmd_op;
    logic [DATA_W-1:0] cmd_data;
    logic [LEN_W-1:0]  cmd_len;

    modport master (
        output cmd_valid,
        output cmd_op,
        output cmd_data,
        output cmd_len,
        input  cmd_ready
    );

    modport slave (
        input  cmd_valid,
        input  cmd_op,
        input  cmd_data,
        input  cmd_len,
        output cmd_ready
    );
endinterface : count_cmd_seq_if
`default_nettype wire

// File: rtl/count_cmd_seq_fifo.sv
`default_nettype none
// ============================================================================
// Module : count_cmd_fifo
// Brief  : Synchronous FIFO holding flattened command records. Head entry is
//          visible combinationally on rdata; push/pop are ignored when full/
//          empty respectively.
// Rev    : 1.0  initial release
// ============================================================================
module count_cmd_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 14
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             push,
    input  wire logic [WIDTH-1:0] wdata,
    input  wire logic             pop,
    output logic      [WIDTH-1:0] rdata,
    output logic                  full,
    output logic                  empty
);
    localparam int             c_AW      = $clog2(DEPTH);
    localparam logic [c_AW:0]  c_PTR_ONE = (c_AW+1)'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW:0]    r_wr_ptr;
    logic [c_AW:0]    r_rd_ptr;
    logic             w_wr_en;
    logic             w_rd_en;

    // Extra pointer MSB distinguishes full from empty when the indices match.
    assign full    = (r_wr_ptr[c_AW] != r_rd_ptr[c_AW]) &&
                     (r_wr_ptr[c_AW-1:0] == r_rd_ptr[c_AW-1:0]);
    assign empty   = (r_wr_ptr == r_rd_ptr);
    assign w_wr_en = push && !full;
    assign w_rd_en = pop && !empty;
    assign rdata   = r_mem[r_rd_ptr[c_AW-1:0]];

    // Storage array: no reset needed, validity is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_mem[r_wr_ptr[c_AW-1:0]] <= wdata;
        end
    end

    // Read/write pointers; reset flushes the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_wr_en) r_wr_ptr <= r_wr_ptr + c_PTR_ONE;
            if (w_rd_en) r_rd_ptr <= r_rd_ptr + c_PTR_ONE;
        end
    end
endmodule : count_cmd_fifo
`default_nettype wire

// File: rtl/count_cmd_seq.sv
`default_nettype none
// ============================================================================
// Module : count_cmd_seq
// Brief  : Stimulus sequencer for a 4-bit up/down counter. Buffers LOAD/UP/
//          DOWN commands, drives din/load/up_down cycle-accurately and keeps
//          a registered model of the counter value (exp_count).
// Rev    : 1.0  initial release
// ============================================================================
module count_cmd_seq
    import count_cmd_seq_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int LEN_W      = 8,
    parameter int DATA_W     = 4
) (
    input  wire logic              clk,
    input  wire logic              rst,
    count_cmd_seq_if.slave         cmd,
    output logic      [DATA_W-1:0] din,
    output logic                   load,
    output logic                   up_down,
    output logic                   busy,
    output logic                   done,
    output logic                   err,
    output logic      [DATA_W-1:0] exp_count
);
    typedef struct packed {
        cmd_op_e           op;
        logic [DATA_W-1:0] data;
        logic [LEN_W-1:0]  len;
    } entry_t;

    localparam int c_ENTRY_W = $bits(entry_t);

    entry_t             w_wr_entry;
    entry_t             w_head;
    logic [c_ENTRY_W-1:0] w_rdata;
    logic               w_full;
    logic               w_empty;
    logic               w_push;
    logic               w_pop;
    logic               w_last;
    logic               w_head_drive;

    cmd_state_e         r_state;
    cmd_state_e         w_state_nxt;
    logic [LEN_W-1:0]   r_remain;
    logic [LEN_W-1:0]   w_remain_nxt;
    logic [DATA_W-1:0]  w_din_nxt;
    logic               w_load_nxt;
    logic               w_up_down_nxt;
    logic               w_done_nxt;
    logic               w_err_nxt;

    assign cmd.cmd_ready = !w_full;
    assign w_push        = cmd.cmd_valid && !w_full;
    assign w_wr_entry    = '{op: cmd.cmd_op, data: cmd.cmd_data, len: cmd.cmd_len};
    assign w_head        = entry_t'(w_rdata);

    count_cmd_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (c_ENTRY_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (w_push),
        .wdata (w_wr_entry),
        .pop   (w_pop),
        .rdata (w_rdata),
        .full  (w_full),
        .empty (w_empty)
    );

    // Last drive cycle of the current command: hand-over point for the next.
    assign w_last = (r_state == ST_LOAD) ||
                    ((r_state == ST_RUN) && (r_remain == LEN_W'(1)));
    assign w_head_drive = is_drive_cmd(w_head.op, w_head.len != '0);

    // From the last drive cycle only a driving command is chained in, so a
    // zero-length/reserved command always retires from IDLE and its done
    // pulse never coincides with the retiring command's pulse.
    assign w_pop = !w_empty && ((r_state == ST_IDLE) || (w_last && w_head_drive));

    assign busy = (r_state != ST_IDLE) || !w_empty;

    // Next-state, run-length and counter-pin decode.
    always_comb begin
        w_state_nxt   = r_state;
        w_remain_nxt  = r_remain;
        w_din_nxt     = din;
        w_load_nxt    = load;
        w_up_down_nxt = up_down;
        w_done_nxt    = 1'b0;
        w_err_nxt     = err;

        case (r_state)
            ST_LOAD, ST_RUN: begin
                if (r_state == ST_RUN) w_remain_nxt = r_remain - LEN_W'(1);
                if (w_last) begin
                    w_state_nxt = ST_IDLE;
                    w_load_nxt  = 1'b0;
                    w_done_nxt  = 1'b1;
                end
            end
            default: ;
        endcase

        if (w_pop) begin
            case (w_head.op)
                OP_LOAD: begin
                    w_state_nxt = ST_LOAD;
                    w_load_nxt  = 1'b1;
                    w_din_nxt   = w_head.data;
                end
                OP_UP, OP_DOWN: begin
                    if (w_head.len != '0) begin
                        w_state_nxt   = ST_RUN;
                        w_remain_nxt  = w_head.len;
                        w_load_nxt    = 1'b0;
                        w_up_down_nxt = (w_head.op == OP_UP);
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
                default: begin
                    w_err_nxt  = 1'b1;
                    w_done_nxt = 1'b1;
                end
            endcase
        end
    end

    // FSM state and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= ST_IDLE;
            r_remain <= '0;
            din      <= '0;
            load     <= 1'b0;
            up_down  <= 1'b1;
            done     <= 1'b0;
            err      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_remain <= w_remain_nxt;
            din      <= w_din_nxt;
            load     <= w_load_nxt;
            up_down  <= w_up_down_nxt;
            done     <= w_done_nxt;
            err      <= w_err_nxt;
        end
    end

    // Counter model, fed by the pins as registered during the previous cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_count <= '0;
        end else if (load) begin
            exp_count <= din;
        end else if (up_down) begin
            exp_count <= exp_count + DATA_W'(1);
        end else begin
            exp_count <= exp_count - DATA_W'(1);
        end
    end
endmodule : count_cmd_seq
`default_nettype wire
